// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access engine: single-outstanding SRAM-like bus master
// with store-lane replication, load extension and alignment exceptions.
module mem_access_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memtoregM,
    input  logic          memwriteM,
    input  logic [2:0]    memopM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    input  logic          pipe_stallM,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata,
    output logic [DW-1:0] readdataM,
    output logic          stallreq_mem,
    output logic          adelM,
    output logic          adesM
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t state, stateNext;

    logic          misaligned;
    logic          valid;
    logic          issue;
    logic          cancel;
    logic          dropResp;
    logic [1:0]    sizeLive;
    logic [DW-1:0] wdataLive;
    logic [AW-1:0] addrQ;
    logic [1:0]    sizeQ;
    logic          wrQ;
    logic [DW-1:0] wdataQ;
    logic [2:0]    opQ;
    logic [7:0]    rawByte;
    logic [15:0]   rawHalf;
    logic [DW-1:0] loadExt;

    always_comb begin
        sizeLive = 2'd0;
        unique case (memopM)
            3'b000, 3'b101:         sizeLive = 2'd2;
            3'b001, 3'b010, 3'b110: sizeLive = 2'd1;
            default:                sizeLive = 2'd0;
        endcase
    end

    always_comb begin
        wdataLive = writedataM;
        unique case (sizeLive)
            2'd0:    wdataLive = {4{writedataM[7:0]}};
            2'd1:    wdataLive = {2{writedataM[15:0]}};
            default: wdataLive = writedataM;
        endcase
    end

    assign misaligned = (sizeLive == 2'd1 && aluoutM[0])
                      || (sizeLive == 2'd2 && aluoutM[1:0] != 2'b00);
    assign valid = (memtoregM | memwriteM) & ~flushM & ~misaligned;
    assign adelM = memtoregM & ~flushM & misaligned;
    assign adesM = memwriteM & ~flushM & misaligned;

    assign stallreq_mem = (valid && state != DONE)
                        || state == REQ || state == WAIT;

    // A flush arriving with the response itself also drops that response.
    assign dropResp = cancel | flushM;

    always_comb begin
        stateNext  = state;
        issue      = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = '0;
        data_wdata = '0;
        unique case (state)
            IDLE: begin
                if (valid) begin
                    issue      = 1'b1;
                    data_req   = 1'b1;
                    data_wr    = memwriteM;
                    data_size  = sizeLive;
                    data_addr  = aluoutM;
                    data_wdata = wdataLive;
                    stateNext  = data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                data_req   = 1'b1;
                data_wr    = wrQ;
                data_size  = sizeQ;
                data_addr  = addrQ;
                data_wdata = wdataQ;
                if (data_addr_ok) stateNext = WAIT;
            end
            WAIT: begin
                if (data_data_ok) begin
                    stateNext = dropResp ? IDLE : DONE;
                end
            end
            DONE: begin
                if (flushM || !pipe_stallM) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        rawByte = data_rdata[7:0];
        unique case (addrQ[1:0])
            2'd0: rawByte = data_rdata[7:0];
            2'd1: rawByte = data_rdata[15:8];
            2'd2: rawByte = data_rdata[23:16];
            2'd3: rawByte = data_rdata[31:24];
        endcase
        rawHalf = addrQ[1] ? data_rdata[31:16] : data_rdata[15:0];
        loadExt = data_rdata;
        unique case (opQ)
            3'b001:  loadExt = {{16{rawHalf[15]}}, rawHalf};
            3'b010:  loadExt = {16'h0, rawHalf};
            3'b011:  loadExt = {{24{rawByte[7]}}, rawByte};
            3'b100:  loadExt = {24'h0, rawByte};
            default: loadExt = data_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cancel    <= 1'b0;
            addrQ     <= '0;
            sizeQ     <= 2'd0;
            wrQ       <= 1'b0;
            wdataQ    <= '0;
            opQ       <= 3'd0;
            readdataM <= '0;
        end else begin
            state <= stateNext;
            if (issue) begin
                addrQ  <= aluoutM;
                sizeQ  <= sizeLive;
                wrQ    <= memwriteM;
                wdataQ <= wdataLive;
                opQ    <= memopM;
            end
            if (state == WAIT && data_data_ok) begin
                cancel <= 1'b0;
            end else if (flushM && (state == REQ || state == WAIT)) begin
                cancel <= 1'b1;
            end
            if (state == WAIT && data_data_ok && !dropResp && !wrQ) begin
                readdataM <= loadExt;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus
// randomized accesses against a behavioural model of the bus engine.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoregM, memwriteM;
    logic [2:0]  memopM;
    logic [31:0] aluoutM, writedataM;
    logic        flushM, pipe_stallM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, readdataM;
    logic        stallreq_mem, adelM, adesM;

    int nCompared = 0;
    int nMismatched = 0;
    logic [31:0] lastLoad = 32'h0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .memtoregM(memtoregM), .memwriteM(memwriteM),
        .memopM(memopM), .aluoutM(aluoutM),
        .writedataM(writedataM), .flushM(flushM),
        .pipe_stallM(pipe_stallM),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .readdataM(readdataM),
        .stallreq_mem(stallreq_mem), .adelM(adelM), .adesM(adesM)
    );

    function automatic int nBytes(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd5) return 4;
        if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] op,
                                               input logic [31:0] wd);
        int n = nBytes(op);
        if (n == 1) return {24'h0, wd[7:0]} * 32'h01010101;
        if (n == 2) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] op,
                                              input logic [31:0] addr,
                                              input logic [31:0] rd);
        int bits;
        logic [31:0] mask, val;
        bit isSigned;
        if (op == 3'd0) return rd;
        bits = 8 * nBytes(op);
        mask = (32'h1 << bits) - 32'h1;
        val = (rd >> (8 * addr[1:0])) & mask;
        isSigned = (op == 3'd1 || op == 3'd3);
        if (isSigned && val[bits-1]) val = val | ~mask;
        return val;
    endfunction

    task automatic setAccess(input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd);
        memopM = op;
        memtoregM = (op < 3'd5);
        memwriteM = (op >= 3'd5);
        aluoutM = addr;
        writedataM = wd;
    endtask

    task automatic goIdle;
        memtoregM = 1'b0;
        memwriteM = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({data_req, stallreq_mem} !== 2'b00) begin
            nMismatched++;
            $display("FAIL idle_quiet: req/stall %b want 00",
                     {data_req, stallreq_mem});
        end
        @(posedge clk); #1;
    endtask

    // Drives one access through request, response and DONE phases.
    task automatic doAccess(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int addrLat, input int dataLat,
                            input int holdDone, input bit flushDone);
        logic isLoad;
        logic [1:0] sz;
        logic [31:0] expW;
        int n;
        isLoad = (op < 3'd5);
        n = nBytes(op);
        sz = (n == 4) ? 2'd2 : ((n == 2) ? 2'd1 : 2'd0);
        expW = modelWdata(op, wd);
        setAccess(op, addr, wd);
        if (addr % n != 0) begin
            @(negedge clk);
            nCompared++;
            if ({adelM, adesM} !== {isLoad, ~isLoad}) begin
                nMismatched++;
                $display("FAIL misalign_exc: adel/ades %b%b want %b%b",
                         adelM, adesM, isLoad, ~isLoad);
            end
            nCompared++;
            if ({data_req, stallreq_mem} !== 2'b00) begin
                nMismatched++;
                $display("FAIL misalign_quiet: req/stall %b want 00",
                         {data_req, stallreq_mem});
            end
            @(posedge clk); #1;
            return;
        end
        for (int c = 0; c <= addrLat; c++) begin
            data_addr_ok = (c == addrLat);
            if (c > 0) begin
                aluoutM = $urandom;
                writedataM = $urandom;
                data_data_ok = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            nCompared++;
            if ({data_req, data_wr, data_size, data_addr, data_wdata,
                 stallreq_mem} !== {1'b1, ~isLoad, sz, addr, expW, 1'b1}) begin
                nMismatched++;
                $display("FAIL req_payload c%0d: req%b wr%b sz%0d a%h d%h st%b want req1 wr%b sz%0d a%h d%h st1",
                         c, data_req, data_wr, data_size, data_addr,
                         data_wdata, stallreq_mem, ~isLoad, sz, addr, expW);
            end
            if (c == 0) begin
                nCompared++;
                if ({adelM, adesM} !== 2'b00) begin
                    nMismatched++;
                    $display("FAIL aligned_exc: adel/ades %b%b want 00",
                             adelM, adesM);
                end
            end
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        aluoutM = addr;
        writedataM = wd;
        for (int c = 0; c <= dataLat; c++) begin
            data_data_ok = (c == dataLat);
            data_rdata = data_data_ok ? rd : $urandom;
            @(negedge clk);
            nCompared++;
            if ({data_req, stallreq_mem} !== 2'b01) begin
                nMismatched++;
                $display("FAIL wait_phase c%0d: req/stall %b want 01",
                         c, {data_req, stallreq_mem});
            end
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        data_rdata = $urandom;
        if (isLoad) lastLoad = modelLoad(op, addr, rd);
        for (int c = 0; c <= holdDone; c++) begin
            pipe_stallM = (c < holdDone) || flushDone;
            flushM = flushDone && (c == holdDone);
            @(negedge clk);
            nCompared++;
            if ({data_req, stallreq_mem} !== 2'b00) begin
                nMismatched++;
                $display("FAIL done_phase c%0d: req/stall %b want 00",
                         c, {data_req, stallreq_mem});
            end
            if (isLoad) begin
                nCompared++;
                if (readdataM !== lastLoad) begin
                    nMismatched++;
                    $display("FAIL load_data op%0d a%h: got %h want %h",
                             op, addr, readdataM, lastLoad);
                end
            end
            @(posedge clk); #1;
        end
        pipe_stallM = 1'b0;
        flushM = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        goIdleInputs();
        #1 rst = 1'b0;
        #2;
        nCompared++;
        if ({data_req, data_wr, data_size, data_addr, data_wdata, readdataM,
             stallreq_mem} !== '0) begin
            nMismatched++;
            $display("FAIL reset_outputs: req%b wr%b sz%0d a%h d%h r%h st%b want all 0",
                     data_req, data_wr, data_size, data_addr, data_wdata,
                     readdataM, stallreq_mem);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic goIdleInputs;
        memtoregM = 1'b0;
        memwriteM = 1'b0;
        memopM = 3'd0;
        aluoutM = '0;
        writedataM = '0;
        flushM = 1'b0;
        pipe_stallM = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = '0;
    endtask

    task automatic test_loads;
        doAccess(3'd0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
        doAccess(3'd3, 32'h1003, 32'h0, 32'h80112233, 0, 0, 0, 1'b0);
        doAccess(3'd4, 32'h1003, 32'h0, 32'h80112233, 0, 1, 0, 1'b0);
        doAccess(3'd2, 32'h1002, 32'h0, 32'h80112233, 0, 0, 0, 1'b0);
        doAccess(3'd1, 32'h1002, 32'h0, 32'h80112233, 1, 2, 0, 1'b0);
        goIdle();
    endtask

    task automatic test_stores;
        doAccess(3'd7, 32'h2001, 32'h000000A5, 32'h0, 0, 0, 0, 1'b0);
        doAccess(3'd6, 32'h2002, 32'h000000A5, 32'h0, 0, 0, 0, 1'b0);
        doAccess(3'd5, 32'h2004, 32'h13572468, 32'h0, 0, 1, 0, 1'b0);
        goIdle();
    endtask

    task automatic test_addr_delay;
        doAccess(3'd0, 32'h1010, 32'h0, 32'h0BADF00D, 3, 0, 0, 1'b0);
        doAccess(3'd7, 32'h2003, 32'h0000005C, 32'h0, 3, 2, 0, 1'b0);
        goIdle();
    endtask

    task automatic test_misaligned;
        doAccess(3'd0, 32'h1002, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        doAccess(3'd6, 32'h00000003, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        doAccess(3'd1, 32'h1001, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        doAccess(3'd5, 32'h2001, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        goIdle();
    endtask

    task automatic test_flush;
        doAccess(3'd0, 32'h1000, 32'h0, 32'h12345678, 0, 0, 0, 1'b0);
        setAccess(3'd0, 32'h1100, 32'h0);
        data_addr_ok = 1'b1;
        @(negedge clk);
        nCompared++;
        if (data_req !== 1'b1) begin
            nMismatched++;
            $display("FAIL flush_issue: req %b want 1", data_req);
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        flushM = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({data_req, stallreq_mem} !== 2'b01) begin
            nMismatched++;
            $display("FAIL flush_wait: req/stall %b want 01",
                     {data_req, stallreq_mem});
        end
        @(posedge clk); #1;
        flushM = 1'b0;
        setAccess(3'd0, 32'h1204, 32'h0);
        for (int c = 0; c <= 2; c++) begin
            data_data_ok = (c == 2);
            data_rdata = 32'hBAD0BAD0;
            @(negedge clk);
            nCompared++;
            if ({data_req, stallreq_mem} !== 2'b01) begin
                nMismatched++;
                $display("FAIL flush_block c%0d: req/stall %b want 01",
                         c, {data_req, stallreq_mem});
            end
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        nCompared++;
        if (readdataM !== lastLoad) begin
            nMismatched++;
            $display("FAIL flush_discard: got %h want %h",
                     readdataM, lastLoad);
        end
        doAccess(3'd0, 32'h1204, 32'h0, 32'hCAFEF00D, 1, 0, 2, 1'b0);
        goIdle();
    endtask

    task automatic test_done_flush;
        doAccess(3'd4, 32'h1001, 32'h0, 32'h00C30000, 0, 0, 1, 1'b1);
        doAccess(3'd0, 32'h1008, 32'h0, 32'h55AA55AA, 0, 0, 0, 1'b0);
        goIdle();
    endtask

    task automatic test_back_to_back;
        doAccess(3'd0, 32'h3000, 32'h0, 32'h01020304, 0, 0, 0, 1'b0);
        doAccess(3'd5, 32'h3004, 32'hFEEDFACE, 32'h0, 0, 0, 0, 1'b0);
        doAccess(3'd3, 32'h3002, 32'h0, 32'h00FF0000, 0, 0, 0, 1'b0);
        goIdle();
    endtask

    task automatic test_mid_reset;
        setAccess(3'd0, 32'h4000, 32'h0);
        data_addr_ok = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++;
        if (data_req !== 1'b1) begin
            nMismatched++;
            $display("FAIL midrst_req: req %b want 1", data_req);
        end
        memtoregM = 1'b0;
        rst = 1'b0;
        #1;
        nCompared++;
        if ({data_req, stallreq_mem, readdataM} !== '0) begin
            nMismatched++;
            $display("FAIL midrst_clear: req%b st%b r%h want 0",
                     data_req, stallreq_mem, readdataM);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        lastLoad = 32'h0;
        goIdle();
    endtask

    task automatic test_random;
        logic [2:0] op;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                addr = addr & ~32'(nBytes(op) - 1);
            end
            doAccess(op, addr, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), 1'b0);
            if ($urandom_range(0, 1) == 1) goIdle();
        end
        goIdle();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_addr_delay();
        test_misaligned();
        test_flush();
        test_done_flush();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data-access engine that consumes the M-stage control bundle (memtoregM, memwriteM, memopM) produced by the controller.
- Drives a single-outstanding SRAM-like data bus (req / addr_ok / data_ok) and returns a stall request to the hazard unit.
- Aligns store data and byte/half-extends load data.
- Raises alignment exceptions instead of issuing misaligned accesses.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32, byte lanes assumed.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets immediately.
- memtoregM  in  1  M-stage instruction is a load.
- memwriteM  in  1  M-stage instruction is a store.
- memopM  in  3  access op: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- aluoutM  in  AW  effective address.
- writedataM  in  DW  rt value for stores.
- flushM  in  1  M-stage instruction cancelled (exception/eret).
- pipe_stallM  in  1  M stage held for reasons other than this block.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  AW  byte address.
- data_wdata  out  DW  lane-replicated store data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  response this cycle (read data valid / write done).
- data_rdata  in  DW  raw read word.
- readdataM  out  DW  extended load result.
- stallreq_mem  out  1  hold pipeline at M.
- adelM  out  1  load address error.
- adesM  out  1  store address error.

Behaviour:
- Access definition: valid = (memtoregM | memwriteM) & ~flushM & ~misaligned.
- Misalignment:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Misaligned loads assert adelM; misaligned stores assert adesM. Both are combinational and gated by ~flushM.
  - A misaligned access never issues data_req and never stalls.
- States: IDLE, REQ, WAIT, DONE. On reset: IDLE, readdataM=0, internal cancel flag=0, all bus outputs 0.
- IDLE:
  - data_req = valid, combinational.
  - valid & addr_ok → WAIT.
  - valid & ~addr_ok → REQ.
- REQ:
  - data_req=1.
  - addr, size, wr and wdata come from registers latched at issue.
  - addr_ok → WAIT.
- WAIT:
  - data_req=0.
  - On data_ok: capture data_rdata, then go to DONE, or to IDLE if cancel=1.
- DONE:
  - readdataM is driven from the captured word.
  - Stay while pipe_stallM=1; else → IDLE.
  - No reissue while in DONE.
- Request persistence: once data_req is high it stays high with stable payload until addr_ok. Bus payload is registered at entry to REQ.
- Stall:
  - stallreq_mem = (valid & state∈{IDLE,REQ,WAIT}) | state∈{REQ,WAIT}.
  - High during the data_ok cycle; low in DONE.
  - Minimum latency with addr_ok and data_ok both same-cycle-next: request in cycle 0, data_ok in cycle 1, DONE in cycle 2, stall high for cycles 0–1.
- Flush:
  - flushM in REQ or WAIT sets cancel=1. The transaction still completes on the bus, and the response is dropped.
  - stallreq_mem stays high until the response returns, so a following access cannot issue while one is outstanding.
  - cancel clears on data_ok.
  - flushM in DONE → IDLE next edge.
- Store data:
  - SB replicates byte on all 4 lanes.
  - SH replicates half on both halves.
  - SW passes through.
- Load extension (from captured word, using latched addr[1:0]):
  - LB/LBU select byte addr[1:0], sign- or zero-extended.
  - LH/LHU select half addr[1], sign- or zero-extended.
  - LW passes through.
- Simultaneous addr_ok and data_ok in WAIT is impossible (single outstanding request); data_ok while in IDLE or REQ is ignored.
- Reset asserted mid-transaction: immediate IDLE and data_req=0. The bus slave is assumed reset together.

Test Plan:
- LW addr 0x1000, addr_ok same cycle, data_ok next cycle with rdata=0xDEADBEEF → req high 1 cycle, stall cycles 0–1, readdataM=0xDEADBEEF in DONE.
- LB addr 0x1003, rdata=0x80112233 → readdataM=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x1002 → 0x00008011.
- SB addr 0x2001, writedataM=0x000000A5 → data_wr=1, size=0, wdata=0xA5A5A5A5; SH gives size=1, wdata=0x00A500A5.
- addr_ok delayed 3 cycles → data_req and payload stable all 3 cycles, state REQ, stall held, single transaction.
- LW addr 0x1002 → adelM=1, no data_req, no stall; SH addr 0x3 → adesM=1.
- flushM in WAIT, then a new LW arrives → no new req until old data_ok, old data discarded, new access issues the cycle after; pipe_stallM=1 in DONE holds readdataM with no reissue.
